// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: gates PC/IF-ID/imem and owns a one-entry
// redirect buffer whose operands are presented to fetch until the redirect applies.
module fetch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             stall,
    input  logic             halt,
    input  logic             redir_valid,
    output logic             redir_ready,
    input  logic [1:0]       redir_type,
    input  logic [31:0]      redir_brPC,
    input  logic [15:0]      redir_imm,
    input  logic [31:0]      redir_jraddr,
    input  logic [31:0]      redir_jPC,
    input  logic [25:0]      redir_jaddr,
    output logic             pcen,
    output logic [1:0]       PCSrc,
    output logic [31:0]      brPC,
    output logic [15:0]      imm,
    output logic [31:0]      jraddr,
    output logic [31:0]      jPC,
    output logic [25:0]      jaddr,
    output logic             imemREN,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             halted,
    output logic [CNT_W-1:0] redir_count
);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       r_type;
    logic [31:0]      r_brPC;
    logic [15:0]      r_imm;
    logic [31:0]      r_jraddr;
    logic [31:0]      r_jPC;
    logic [25:0]      r_jaddr;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;

    // halt outranks a same-cycle redirect, so it is folded into accept itself
    assign redir_ready = ~RST & (r_state == S_RUN);
    assign w_accept    = redir_valid & redir_ready & (redir_type != 2'd0) & ~halt;

    assign brPC        = r_brPC;
    assign imm         = r_imm;
    assign jraddr      = r_jraddr;
    assign jPC         = r_jPC;
    assign jaddr       = r_jaddr;
    assign redir_count = r_count;

    always_comb begin
        pcen       = 1'b0;
        PCSrc      = 2'd0;
        imemREN    = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        halted     = 1'b0;
        if (RST) begin
            ifid_flush = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    imemREN = 1'b1;
                    if (w_accept) begin
                        ifid_flush = 1'b1;
                    end else begin
                        pcen    = ihit & ~stall;
                        ifid_en = ihit & ~stall;
                    end
                end
                // stall is ignored here: everything younger is being flushed anyway
                S_PEND: begin
                    PCSrc      = r_type;
                    imemREN    = 1'b1;
                    ifid_flush = 1'b1;
                    pcen       = ihit;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    ifid_flush = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_RUN;
            r_type   <= 2'd0;
            r_brPC   <= 32'd0;
            r_imm    <= 16'd0;
            r_jraddr <= 32'd0;
            r_jPC    <= 32'd0;
            r_jaddr  <= 26'd0;
            r_count  <= '0;
        end else if (halt) begin
            r_state <= S_HALT;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        r_state  <= S_PEND;
                        r_type   <= redir_type;
                        r_brPC   <= redir_brPC;
                        r_imm    <= redir_imm;
                        r_jraddr <= redir_jraddr;
                        r_jPC    <= redir_jPC;
                        r_jaddr  <= redir_jaddr;
                    end
                end
                S_PEND: begin
                    if (ihit) begin
                        r_state <= S_RUN;
                        if (r_count != CNT_MAX) begin
                            r_count <= r_count + CNT_ONE;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_fetch_ctrl;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST;
    logic             ihit;
    logic             stall;
    logic             halt;
    logic             redir_valid;
    logic             redir_ready;
    logic [1:0]       redir_type;
    logic [31:0]      redir_brPC;
    logic [15:0]      redir_imm;
    logic [31:0]      redir_jraddr;
    logic [31:0]      redir_jPC;
    logic [25:0]      redir_jaddr;
    logic             pcen;
    logic [1:0]       PCSrc;
    logic [31:0]      brPC;
    logic [15:0]      imm;
    logic [31:0]      jraddr;
    logic [31:0]      jPC;
    logic [25:0]      jaddr;
    logic             imemREN;
    logic             ifid_en;
    logic             ifid_flush;
    logic             halted;
    logic [CNT_W-1:0] redir_count;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    fetch_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .halt(halt),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_type(redir_type),
        .redir_brPC(redir_brPC), .redir_imm(redir_imm), .redir_jraddr(redir_jraddr),
        .redir_jPC(redir_jPC), .redir_jaddr(redir_jaddr),
        .pcen(pcen), .PCSrc(PCSrc), .brPC(brPC), .imm(imm), .jraddr(jraddr),
        .jPC(jPC), .jaddr(jaddr), .imemREN(imemREN), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .halted(halted), .redir_count(redir_count)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = idle/running, 1 = redirect waiting, 2 = halted
    int          mMode;
    logic [1:0]  mType;
    logic [31:0] mBr, mJr, mJPC;
    logic [15:0] mImm;
    logic [25:0] mJaddr;
    int          mCount;
    bit          mReady = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            mMode = 0; mType = 0; mBr = 0; mImm = 0; mJr = 0; mJPC = 0; mJaddr = 0;
            mCount = 0; mReady = 1'b1;
        end else if (mReady) begin
            if (halt) begin
                mMode = 2;
            end else if (mMode == 0 && redir_valid && redir_type != 2'd0) begin
                mMode = 1; mType = redir_type; mBr = redir_brPC; mImm = redir_imm;
                mJr = redir_jraddr; mJPC = redir_jPC; mJaddr = redir_jaddr;
            end else if (mMode == 1 && ihit) begin
                mMode = 0;
                if (mCount < CNT_MAX) mCount++;
            end
        end
    end

    // Fetch-stage stand-in: follows the controller's PC select like real fetch would
    logic [31:0] fetchPC;
    always @(posedge CLK) begin
        if (RST) fetchPC <= 32'd0;
        else if (pcen) begin
            case (PCSrc)
                2'd0: fetchPC <= fetchPC + 32'd4;
                2'd1: fetchPC <= jraddr;
                2'd2: fetchPC <= {jPC[31:28], jaddr, 2'b00};
                default: fetchPC <= brPC + {{14{imm[15]}}, imm, 2'b00};
            endcase
        end
    end

    always @(negedge CLK) begin
        if (mReady) begin
            logic eReady, eAccept, ePcen, eImem, eEn, eFlush, eHalted;
            logic [1:0] eSrc;
            eReady  = !RST && mMode == 0;
            eAccept = eReady && redir_valid && redir_type != 2'd0 && !halt;
            ePcen = 0; eImem = 0; eEn = 0; eFlush = 0; eHalted = 0; eSrc = 0;
            if (RST) eFlush = 1;
            else if (mMode == 0) begin
                eImem = 1; eFlush = eAccept;
                ePcen = !eAccept && ihit && !stall; eEn = ePcen;
            end else if (mMode == 1) begin
                eImem = 1; eFlush = 1; ePcen = ihit; eSrc = mType;
            end else eHalted = 1;
            checkOutput("redir_ready", 64'(redir_ready), 64'(eReady));
            checkOutput("pcen", 64'(pcen), 64'(ePcen));
            checkOutput("imemREN", 64'(imemREN), 64'(eImem));
            checkOutput("ifid_en", 64'(ifid_en), 64'(eEn));
            checkOutput("ifid_flush", 64'(ifid_flush), 64'(eFlush));
            checkOutput("halted", 64'(halted), 64'(eHalted));
            if (RST || mMode != 2) checkOutput("PCSrc", 64'(PCSrc), 64'(eSrc));
            checkOutput("redir_count", 64'(redir_count), 64'(mCount));
            checkOutput("brPC", 64'(brPC), 64'(mBr));
            checkOutput("imm", 64'(imm), 64'(mImm));
            checkOutput("jraddr", 64'(jraddr), 64'(mJr));
            checkOutput("jPC", 64'(jPC), 64'(mJPC));
            checkOutput("jaddr", 64'(jaddr), 64'(mJaddr));
        end
    end

    // Drives one cycle of inputs just after the edge, returns at the following negedge
    task automatic applyStimulus(input logic rst, input logic ih, input logic st, input logic hl,
                                 input logic vld, input logic [1:0] typ,
                                 input logic [31:0] br, input logic [15:0] im,
                                 input logic [31:0] jr, input logic [31:0] jp,
                                 input logic [25:0] ja);
        @(posedge CLK);
        #1;
        RST = rst; ihit = ih; stall = st; halt = hl; redir_valid = vld; redir_type = typ;
        redir_brPC = br; redir_imm = im; redir_jraddr = jr; redir_jPC = jp; redir_jaddr = ja;
        @(negedge CLK);
    endtask

    task automatic idle(input logic ih);
        applyStimulus(0, ih, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        RST = 1; ihit = 1; stall = 0; halt = 0; redir_valid = 0; redir_type = 0;
        redir_brPC = 0; redir_imm = 0; redir_jraddr = 0; redir_jPC = 0; redir_jaddr = 0;

        // Reset for two cycles, then sequential fetch 0,4,8
        applyStimulus(1, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        checkOutput("lit_rst_pcen", 64'(pcen), 64'd0);
        checkOutput("lit_rst_flush", 64'(ifid_flush), 64'd1);
        idle(1);
        checkOutput("lit_pc0", 64'(fetchPC), 64'h0);
        checkOutput("lit_run_pcen", 64'(pcen), 64'd1);
        idle(1);
        checkOutput("lit_pc4", 64'(fetchPC), 64'h4);
        idle(1);
        checkOutput("lit_pc8", 64'(fetchPC), 64'h8);

        // Taken branch: 0x40 + (4 << 2)
        applyStimulus(0, 1, 0, 0, 1, 2'd3, 32'h40, 16'h0004, 0, 0, 0);
        checkOutput("lit_acc_pcen", 64'(pcen), 64'd0);
        checkOutput("lit_acc_flush", 64'(ifid_flush), 64'd1);
        idle(1);
        checkOutput("lit_br_src", 64'(PCSrc), 64'd3);
        checkOutput("lit_br_pcen", 64'(pcen), 64'd1);
        idle(0);
        checkOutput("lit_br_pc", 64'(fetchPC), 64'h50);
        checkOutput("lit_cnt1", 64'(redir_count), 64'd1);

        // jr held while imem misses for three cycles
        applyStimulus(0, 1, 0, 0, 1, 2'd1, 0, 0, 32'h1000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
            checkOutput("lit_jr_pcen", 64'(pcen), 64'd0);
            checkOutput("lit_jr_ready", 64'(redir_ready), 64'd0);
            checkOutput("lit_jr_hold", 64'(jraddr), 64'h1000);
            checkOutput("lit_jr_flush", 64'(ifid_flush), 64'd1);
        end
        idle(1);
        idle(0);
        checkOutput("lit_jr_pc", 64'(fetchPC), 64'h1000);

        // Stall in RUN, then a jump accepted despite the stall
        applyStimulus(0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        checkOutput("lit_stall_pcen", 64'(pcen), 64'd0);
        checkOutput("lit_stall_en", 64'(ifid_en), 64'd0);
        applyStimulus(0, 1, 1, 0, 1, 2'd2, 0, 0, 0, 32'hA0000000, 26'h3FFFFFF);
        checkOutput("lit_j_ready", 64'(redir_ready), 64'd1);
        applyStimulus(0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        checkOutput("lit_j_src", 64'(PCSrc), 64'd2);
        idle(1);
        idle(0);
        checkOutput("lit_j_pc", 64'(fetchPC), 64'hAFFFFFFC);

        // halt beats a simultaneous redirect
        applyStimulus(0, 1, 0, 1, 1, 2'd3, 32'h80, 16'h1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            checkOutput("lit_halted", 64'(halted), 64'd1);
            checkOutput("lit_halt_imem", 64'(imemREN), 64'd0);
            checkOutput("lit_halt_cnt", 64'(redir_count), 64'd3);
        end

        // Reset while a redirect is pending discards it
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 2'd3, 32'h1234, 16'h8000, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        checkOutput("lit_rstp_pcen", 64'(pcen), 64'd0);
        checkOutput("lit_rstp_ready", 64'(redir_ready), 64'd0);
        idle(0);
        checkOutput("lit_rstp_br", 64'(brPC), 64'd0);
        checkOutput("lit_rstp_imm", 64'(imm), 64'd0);
        checkOutput("lit_rstp_src", 64'(PCSrc), 64'd0);
        checkOutput("lit_rstp_cnt", 64'(redir_count), 64'd0);

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 64) == 0, ($urandom % 4) != 0, ($urandom % 4) == 0,
                          ($urandom % 128) == 0, 1'($urandom), 2'($urandom), $urandom,
                          16'($urandom), $urandom, $urandom, 26'($urandom));
        end

        // Counter saturation after 2^CNT_W + 1 applied redirects
        applyStimulus(1, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            applyStimulus(0, 1, 0, 0, 1, 2'(1 + ($urandom % 3)), $urandom, 16'($urandom),
                          $urandom, $urandom, 26'($urandom));
            idle(1);
        end
        idle(1);
        checkOutput("lit_cnt_sat", 64'(redir_count), 64'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
